record_song: RTL and testbench

//  Capture side of the audio path: consumes microphone samples from the Audio_Controller input FIFO
//  (audio_in_available / read_audio_in / left,right_channel_audio_in) and writes them into a

---
 rtl/record_song.sv | 115 +++++++++++
 tb/tb_record_song.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/record_song.sv
// Capture side of the audio path: drains the Audio_Controller input FIFO and writes
// (optionally mixed and decimated) samples into a single-port sample RAM.
module record_song #(
  parameter int ADDR_W   = 16,
  parameter int SAMPLE_W = 32,
  parameter int DECIM    = 1,
  parameter int MONO_MIX = 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       stop,
  input  logic                       audio_in_available,
  input  logic signed [SAMPLE_W-1:0] left_in,
  input  logic signed [SAMPLE_W-1:0] right_in,
  output logic                       read_audio_in,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic signed [SAMPLE_W-1:0] mem_data,
  output logic                       mem_wren,
  output logic                       busy,
  output logic                       full,
  output logic                       done,
  output logic [ADDR_W:0]            sample_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_PAUSED  = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;
  localparam logic [7:0] DECIM_LAST = 8'(DECIM - 1);

  logic [1:0]        state;
  logic [7:0]        decim_cnt;
  logic              capture_p0;
  logic              keep_p0;
  logic              last_wr_p1;
  logic [ADDR_W-1:0] ptr_p0;

  // Average in SAMPLE_W+1 bits so the sum never overflows; dropping bit 0 is the >>>1.
  function automatic logic signed [SAMPLE_W-1:0] mix_sample(
    input logic signed [SAMPLE_W-1:0] l,
    input logic signed [SAMPLE_W-1:0] r
  );
    logic [SAMPLE_W:0] sum;
    sum = {l[SAMPLE_W-1], l} + {r[SAMPLE_W-1], r};
    if (MONO_MIX != 0) return sum[SAMPLE_W:1];
    else               return l;
  endfunction

  // The FIFO is always drained so it can never overflow, whatever the state.
  assign read_audio_in = audio_in_available & resetn;

  assign busy       = (state == S_CAPTURE) || (state == S_PAUSED);
  // The write to the last address is in flight: any further pop must be discarded.
  assign last_wr_p1 = mem_wren & (&mem_addr);
  assign capture_p0 = read_audio_in && (state == S_CAPTURE) && !pause && !last_wr_p1;
  assign keep_p0    = capture_p0 && (decim_cnt == 8'd0);
  // A write completing this cycle has not yet bumped sample_count.
  assign ptr_p0     = sample_count[ADDR_W-1:0] + ADDR_W'(mem_wren);

  // ---- stage p0 -> p1: pop decision registered as a RAM write ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      decim_cnt    <= '0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_wren     <= 1'b0;
      full         <= 1'b0;
      done         <= 1'b0;
      sample_count <= '0;
    end else begin
      mem_wren <= keep_p0;
      done     <= 1'b0;
      if (keep_p0) begin
        mem_addr <= ptr_p0;
        mem_data <= mix_sample(left_in, right_in);
      end
      if (capture_p0)
        decim_cnt <= (decim_cnt == DECIM_LAST) ? 8'd0 : decim_cnt + 8'd1;
      if (mem_wren)
        sample_count <= sample_count + 1'b1;
      if (last_wr_p1) begin
        full <= 1'b1;
        done <= 1'b1;
      end

      if (stop) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              state        <= S_CAPTURE;
              sample_count <= '0;
              full         <= 1'b0;
              decim_cnt    <= '0;
            end
          end
          S_CAPTURE: begin
            if (last_wr_p1)  state <= S_DONE;
            else if (pause)  state <= S_PAUSED;
          end
          S_PAUSED: begin
            if (last_wr_p1)  state <= S_DONE;
            else if (!pause) state <= S_CAPTURE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_record_song.sv
// Scoreboarded bench for record_song: three instances (plain, decimating/left-only,
// tiny RAM) share stimulus; each scenario checks the instance selected by sel.
module tb_record_song;

  logic clk = 1'b0;
  logic resetn, start, pause, stop, avail;
  logic signed [31:0] left_in, right_in;

  logic        rd_a, wren_a, busy_a, full_a, done_a;
  logic [15:0] addr_a;
  logic [31:0] data_a;
  logic [16:0] cnt_a;

  logic        rd_d, wren_d, busy_d, full_d, done_d;
  logic [15:0] addr_d;
  logic [31:0] data_d;
  logic [16:0] cnt_d;

  logic        rd_s, wren_s, busy_s, full_s, done_s;
  logic [2:0]  addr_s;
  logic [31:0] data_s;
  logic [3:0]  cnt_s;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  sel     = 0;

  always #5 clk = ~clk;

  record_song #(.ADDR_W(16), .SAMPLE_W(32), .DECIM(1), .MONO_MIX(1)) u_a (
    .clk(clk), .resetn(resetn), .start(start), .pause(pause), .stop(stop),
    .audio_in_available(avail), .left_in(left_in), .right_in(right_in),
    .read_audio_in(rd_a), .mem_addr(addr_a), .mem_data(data_a), .mem_wren(wren_a),
    .busy(busy_a), .full(full_a), .done(done_a), .sample_count(cnt_a));

  record_song #(.ADDR_W(16), .SAMPLE_W(32), .DECIM(3), .MONO_MIX(0)) u_d (
    .clk(clk), .resetn(resetn), .start(start), .pause(pause), .stop(stop),
    .audio_in_available(avail), .left_in(left_in), .right_in(right_in),
    .read_audio_in(rd_d), .mem_addr(addr_d), .mem_data(data_d), .mem_wren(wren_d),
    .busy(busy_d), .full(full_d), .done(done_d), .sample_count(cnt_d));

  record_song #(.ADDR_W(3), .SAMPLE_W(32), .DECIM(1), .MONO_MIX(1)) u_s (
    .clk(clk), .resetn(resetn), .start(start), .pause(pause), .stop(stop),
    .audio_in_available(avail), .left_in(left_in), .right_in(right_in),
    .read_audio_in(rd_s), .mem_addr(addr_s), .mem_data(data_s), .mem_wren(wren_s),
    .busy(busy_s), .full(full_s), .done(done_s), .sample_count(cnt_s));

  function automatic logic [31:0] mix(input logic signed [31:0] l, input logic signed [31:0] r);
    longint s;
    s = longint'(l) + longint'(r);
    s = s >>> 1;
    return s[31:0];
  endfunction

  task automatic push(input logic [15:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Advance one clock and pop the scoreboard for any write the selected instance makes.
  task automatic tick();
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
    wr_t         e;
    @(posedge clk);
    #1;
    case (sel)
      1:       begin w = wren_d; a = addr_d;           d = data_d; end
      2:       begin w = wren_s; a = {13'd0, addr_s};  d = data_s; end
      default: begin w = wren_a; a = addr_a;           d = data_a; end
    endcase
    if (w) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write dut=%0d addr=%0d data=%0d, required no write", sel, a, $signed(d));
      end else begin
        e = exp_q.pop_front();
        if (a !== e.addr || d !== e.data) begin
          n_fail++;
          $display("FAIL write dut=%0d addr=%0d data=%0d, required addr=%0d data=%0d",
                   sel, a, $signed(d), e.addr, $signed(e.data));
        end
      end
    end
  endtask

  task automatic feed(input logic signed [31:0] l, input logic signed [31:0] r,
                      input bit keep, input logic [15:0] a, input logic [31:0] d);
    avail    = 1'b1;
    left_in  = l;
    right_in = r;
    if (keep) push(a, d);
    tick();
    n_tests++;
    if (rd_a !== 1'b1) begin
      n_fail++;
      $display("FAIL read_follows_avail got=%b required=1", rd_a);
    end
    avail = 1'b0;
  endtask

  task automatic begin_rec();
    stop = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_drained(input string name);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_writes got=%0d pending required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    sel = 0;
    #12;
    n_tests++;
    if ({wren_a, busy_a, full_a, done_a, rd_a} !== 5'b0 || cnt_a !== 17'd0 ||
        addr_a !== 16'd0 || data_a !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state wren=%b busy=%b full=%b done=%b rd=%b cnt=%0d addr=%0d data=%0d required all 0",
               wren_a, busy_a, full_a, done_a, rd_a, cnt_a, addr_a, data_a);
    end
    avail = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    n_tests++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset busy=%b required=0", busy_a);
    end
  endtask

  task automatic test_basic();
    sel = 0;
    begin_rec();
    n_tests++;
    if (busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy got=%b required=1", busy_a);
    end
    feed(100, 200, 1, 16'd0, 32'd150);   tick(); tick();
    feed(-4, 2,    1, 16'd1, -32'sd1);   tick(); tick();
    feed(7, 8,     1, 16'd2, 32'd7);     tick(); tick();
    feed(-1, -1,   1, 16'd3, -32'sd1);   tick(); tick();
    n_tests++;
    if (cnt_a !== 17'd4) begin
      n_fail++;
      $display("FAIL basic_count got=%0d required=4", cnt_a);
    end
    check_drained("basic");
  endtask

  task automatic test_decim();
    logic signed [31:0] l;
    sel = 1;
    begin_rec();
    for (int i = 0; i < 7; i++) begin
      l = 1000 + i;
      feed(l, -i, (i % 3) == 0, 16'(i / 3), l);
    end
    tick(); tick();
    n_tests++;
    if (cnt_d !== 17'd3) begin
      n_fail++;
      $display("FAIL decim_count got=%0d required=3", cnt_d);
    end
    check_drained("decim");
  endtask

  task automatic test_pause();
    sel = 0;
    begin_rec();
    feed(10, 20,  1, 16'd0, mix(10, 20));
    feed(-30, 6,  1, 16'd1, mix(-30, 6));
    pause = 1'b1;
    tick();
    n_tests++;
    if (busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_busy got=%b required=1", busy_a);
    end
    for (int i = 0; i < 5; i++) feed(500 + i, 3, 0, 16'd0, 32'd0);
    pause = 1'b0;
    tick();
    feed(-77, -12, 1, 16'd2, mix(-77, -12));
    tick();
    n_tests++;
    if (cnt_a !== 17'd3 || addr_a !== 16'd2 || data_a !== mix(-77, -12)) begin
      n_fail++;
      $display("FAIL pause_result cnt=%0d addr=%0d data=%0d required cnt=3 addr=2 data=%0d",
               cnt_a, addr_a, $signed(data_a), $signed(mix(-77, -12)));
    end
    check_drained("pause");
  endtask

  task automatic test_stop();
    sel = 0;
    begin_rec();
    feed(5, 7, 1, 16'd0, mix(5, 7));
    avail    = 1'b1;
    left_in  = -9;
    right_in = 3;
    stop     = 1'b1;
    push(16'd1, mix(-9, 3));
    tick();
    stop  = 1'b0;
    avail = 1'b0;
    n_tests++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_idle busy=%b required=0", busy_a);
    end
    tick();
    feed(11, 11, 0, 16'd0, 32'd0);
    tick();
    n_tests++;
    if (cnt_a !== 17'd2) begin
      n_fail++;
      $display("FAIL stop_count got=%0d required=2", cnt_a);
    end
    start = 1'b1;
    stop  = 1'b1;
    tick();
    stop = 1'b0;
    n_tests++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL start_stop_together busy=%b required=0", busy_a);
    end
    tick();
    start = 1'b0;
    n_tests++;
    if (busy_a !== 1'b1 || cnt_a !== 17'd0 || full_a !== 1'b0) begin
      n_fail++;
      $display("FAIL restart busy=%b cnt=%0d full=%b required busy=1 cnt=0 full=0", busy_a, cnt_a, full_a);
    end
    check_drained("stop");
  endtask

  task automatic test_back_to_back();
    logic signed [31:0] l, r;
    int done_cnt;
    sel = 2;
    done_cnt = 0;
    begin_rec();
    for (int i = 0; i < 10; i++) begin
      l = $urandom;
      r = $urandom;
      feed(l, r, i < 8, 16'(i), mix(l, r));
      if (done_s === 1'b1) done_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done_s === 1'b1) done_cnt++;
    end
    n_tests++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL done_pulses got=%0d required=1", done_cnt);
    end
    n_tests++;
    if (full_s !== 1'b1 || busy_s !== 1'b0 || cnt_s !== 4'd8) begin
      n_fail++;
      $display("FAIL full_state full=%b busy=%b cnt=%0d required full=1 busy=0 cnt=8", full_s, busy_s, cnt_s);
    end
    check_drained("back_to_back");
  endtask

  task automatic test_async_reset();
    sel = 0;
    // u_a has stored the 10 back-to-back samples, so the next write lands at address 10.
    avail    = 1'b1;
    left_in  = 40;
    right_in = -2;
    push(16'd10, mix(40, -2));
    tick();
    avail = 1'b0;
    n_tests++;
    if (wren_a !== 1'b1 || full_s !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset wren=%b full_s=%b required 1 1", wren_a, full_s);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_tests++;
    if (wren_a !== 1'b0 || busy_a !== 1'b0 || cnt_a !== 17'd0 || full_s !== 1'b0 || cnt_s !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset wren=%b busy=%b cnt=%0d full_s=%b cnt_s=%0d required all 0",
               wren_a, busy_a, cnt_a, full_s, cnt_s);
    end
    tick();
    resetn = 1'b1;
    tick();
    check_drained("async_reset");
  endtask

  initial begin
    resetn   = 1'b0;
    start    = 1'b0;
    pause    = 1'b0;
    stop     = 1'b0;
    avail    = 1'b1;
    left_in  = '0;
    right_in = '0;
    test_reset();
    test_basic();
    test_decim();
    test_pause();
    test_stop();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
